// File: rtl/id_stage_pipe_if.sv
// Bundle of the ID-stage connections: fetch slot in, IF control out,
// EX/M/W hazard and write-back inputs, ID/EX register outputs.
//
// Handshake: validF qualifies the fetch slot. stallF is back-pressure, so
// while it is high the fetch side must hold pcF/instrF/validF unchanged.
// flushF means the slot being fetched is discarded; it is loaded as a bubble.
interface id_stage_pipe_if #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [WORD_W-1:0] instrF;
  logic [WORD_W-1:0] pcF;
  logic              validF;
  logic              stallF;
  logic              flushF;
  logic              branchTaken;
  logic [WORD_W-1:0] branchTarget;
  logic              regWeE;
  logic              memToRegE;
  logic [REG_AW-1:0] writeRegE;
  logic              regWeM;
  logic              memToRegM;
  logic [REG_AW-1:0] writeRegM;
  logic [WORD_W-1:0] aluOutM;
  logic              regWeW;
  logic [REG_AW-1:0] writeRegW;
  logic [WORD_W-1:0] writeDataW;
  logic              validE;
  logic [WORD_W-1:0] instrE;
  logic [WORD_W-1:0] pcE;
  logic [WORD_W-1:0] readData1E;
  logic [WORD_W-1:0] readData2E;
  logic [REG_AW-1:0] rsE;
  logic [REG_AW-1:0] rtE;
  logic [REG_AW-1:0] rdE;
  logic [REG_AW-1:0] destE;
  logic              isLoadE;
  logic [CNT_W-1:0]  stallCount;

  modport master (
    output instrF, pcF, validF,
    output regWeE, memToRegE, writeRegE,
    output regWeM, memToRegM, writeRegM, aluOutM,
    output regWeW, writeRegW, writeDataW,
    input  stallF, flushF, branchTaken, branchTarget,
    input  validE, instrE, pcE, readData1E, readData2E,
    input  rsE, rtE, rdE, destE, isLoadE, stallCount
  );

  modport slave (
    input  instrF, pcF, validF,
    input  regWeE, memToRegE, writeRegE,
    input  regWeM, memToRegM, writeRegM, aluOutM,
    input  regWeW, writeRegW, writeDataW,
    output stallF, flushF, branchTaken, branchTarget,
    output validE, instrE, pcE, readData1E, readData2E,
    output rsE, rtE, rdE, destE, isLoadE, stallCount
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage of a 5-stage MIPS-like pipe: IF/ID register, register file
// with write-back bypass, hazard detection, branch resolution in ID and the
// ID/EX register.
module id_stage_pipe #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  id_stage_pipe_if.slave bus
);
  localparam int NREG = 2 ** REG_AW;

  logic              validD;
  logic [WORD_W-1:0] instrD;
  logic [WORD_W-1:0] pcD;
  logic [WORD_W-1:0] rf [NREG];

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rsD, rtD, rdD, destD;
  logic [15:0]       imm16;
  logic              isRType, isLoad, isBeq, isBne, isBranch;
  logic [WORD_W-1:0] readData1, readData2, branchOp1, branchOp2, immExt;
  logic              loadUse, branchExHaz, branchMemHaz, stall, taken;

  logic              exValid, exIsLoad;
  logic [WORD_W-1:0] exInstr, exPc, exRd1, exRd2;
  logic [REG_AW-1:0] exRs, exRt, exRdf, exDest;
  logic [CNT_W-1:0]  stallCnt;

  // Field extraction and opcode classification of the instruction in ID
  always_comb begin
    opcode   = instrD[31:26];
    rsD      = instrD[21 +: REG_AW];
    rtD      = instrD[16 +: REG_AW];
    rdD      = instrD[11 +: REG_AW];
    imm16    = instrD[15:0];
    isRType  = (opcode == 6'h00);
    isLoad   = (opcode == 6'h23);
    isBeq    = (opcode == 6'h04);
    isBne    = (opcode == 6'h05);
    isBranch = validD && (isBeq || isBne);
    destD    = '0;
    if (validD && !isBeq && !isBne) destD = isRType ? rdD : rtD;
  end

  // Register-file reads with same-cycle write-back bypass; r0 reads as zero
  always_comb begin
    readData1 = rf[rsD];
    readData2 = rf[rtD];
    if (bus.regWeW && bus.writeRegW == rsD) readData1 = bus.writeDataW;
    if (bus.regWeW && bus.writeRegW == rtD) readData2 = bus.writeDataW;
    if (rsD == '0) readData1 = '0;
    if (rtD == '0) readData2 = '0;
  end

  // Branch comparator operands: ALU results sitting in M forward ahead of the RF
  always_comb begin
    branchOp1 = readData1;
    branchOp2 = readData2;
    if (bus.regWeM && !bus.memToRegM && bus.writeRegM != '0) begin
      if (bus.writeRegM == rsD) branchOp1 = bus.aluOutM;
      if (bus.writeRegM == rtD) branchOp2 = bus.aluOutM;
    end
  end

  // Hazards: load-use, branch on EX result, branch on load still in M
  always_comb begin
    loadUse      = bus.regWeE && bus.memToRegE && bus.writeRegE != '0 &&
                   (bus.writeRegE == rsD || bus.writeRegE == rtD);
    branchExHaz  = isBranch && bus.regWeE && bus.writeRegE != '0 &&
                   (bus.writeRegE == rsD || bus.writeRegE == rtD);
    branchMemHaz = isBranch && bus.regWeM && bus.memToRegM && bus.writeRegM != '0 &&
                   (bus.writeRegM == rsD || bus.writeRegM == rtD);
    stall        = validD && (loadUse || branchExHaz || branchMemHaz);
  end

  // Branch resolution; a stall suppresses the redirect until operands are ready
  always_comb begin
    immExt = {{(WORD_W-16){imm16[15]}}, imm16};
    taken  = validD && !stall &&
             ((isBeq && branchOp1 == branchOp2) || (isBne && branchOp1 != branchOp2));
  end

  assign bus.stallF       = stall;
  assign bus.flushF       = taken;
  assign bus.branchTaken  = taken;
  assign bus.branchTarget = pcD + WORD_W'(4) + (immExt << 2);

  // IF/ID register: hold on stall, load a bubble when the fetch is flushed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validD <= 1'b0;
      instrD <= '0;
      pcD    <= '0;
    end else if (taken) begin
      validD <= 1'b0;
      instrD <= '0;
      pcD    <= bus.pcF;
    end else if (!stall) begin
      validD <= bus.validF;
      instrD <= bus.instrF;
      pcD    <= bus.pcF;
    end
  end

  // Register file write port; r0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (bus.regWeW && bus.writeRegW != '0) begin
      rf[bus.writeRegW] <= bus.writeDataW;
    end
  end

  // ID/EX register: all-zero bubble on stall, otherwise capture decoded slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || stall) begin
      exValid  <= 1'b0;
      exInstr  <= '0;
      exPc     <= '0;
      exRd1    <= '0;
      exRd2    <= '0;
      exRs     <= '0;
      exRt     <= '0;
      exRdf    <= '0;
      exDest   <= '0;
      exIsLoad <= 1'b0;
    end else begin
      exValid  <= validD;
      exInstr  <= instrD;
      exPc     <= pcD;
      exRd1    <= readData1;
      exRd2    <= readData2;
      exRs     <= rsD;
      exRt     <= rtD;
      exRdf    <= rdD;
      exDest   <= destD;
      exIsLoad <= validD && isLoad;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stallCnt <= '0;
    else if (stall && stallCnt != {CNT_W{1'b1}}) stallCnt <= stallCnt + 1'b1;
  end

  assign bus.validE     = exValid;
  assign bus.instrE     = exInstr;
  assign bus.pcE        = exPc;
  assign bus.readData1E = exRd1;
  assign bus.readData2E = exRd2;
  assign bus.rsE        = exRs;
  assign bus.rtE        = exRt;
  assign bus.rdE        = exRdf;
  assign bus.destE      = exDest;
  assign bus.isLoadE    = exIsLoad;
  assign bus.stallCount = stallCnt;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: hazards, branch resolution, bypass, reset.
module tb_id_stage_pipe;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  id_stage_pipe_if #(.WORD_W(32), .REG_AW(5), .CNT_W(16)) bus ();

  id_stage_pipe #(.WORD_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] ADD_R9_R8_R1 = 32'h0101_4820;
  localparam logic [31:0] ADD_R6_R5_R0 = 32'h00A0_3020;
  localparam logic [31:0] ADD_R0_R0_R0 = 32'h0000_0020;
  localparam logic [31:0] BEQ_R3_R4_4  = 32'h1064_0004;
  localparam logic [31:0] BNE_R3_R0_2  = 32'h1460_0002;
  localparam logic [31:0] BEQ_R0_R0_M1 = 32'h1000_FFFF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instrF = '0; bus.pcF = '0; bus.validF = 1'b0;
    bus.regWeE = 1'b0; bus.memToRegE = 1'b0; bus.writeRegE = '0;
    bus.regWeM = 1'b0; bus.memToRegM = 1'b0; bus.writeRegM = '0; bus.aluOutM = '0;
    bus.regWeW = 1'b0; bus.writeRegW = '0; bus.writeDataW = '0;
  endtask

  // Put one instruction into IF/ID; the fetch slot goes invalid afterwards
  task automatic load_if(input logic [31:0] instr, input logic [31:0] pc);
    bus.instrF = instr; bus.pcF = pc; bus.validF = 1'b1;
    tick();
    bus.validF = 1'b0; bus.instrF = '0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    bus.regWeW = 1'b1; bus.writeRegW = r; bus.writeDataW = d;
    tick();
    bus.regWeW = 1'b0; bus.writeRegW = '0; bus.writeDataW = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tick(); tick();
    total_cnt++; if (bus.validE !== 1'b0) $display("FAIL rst_validE got=%0h exp=0", bus.validE); else pass_cnt++;
    total_cnt++; if (bus.instrE !== 32'h0) $display("FAIL rst_instrE got=%0h exp=0", bus.instrE); else pass_cnt++;
    total_cnt++; if (bus.pcE !== 32'h0) $display("FAIL rst_pcE got=%0h exp=0", bus.pcE); else pass_cnt++;
    total_cnt++; if (bus.stallCount !== 16'h0) $display("FAIL rst_stallCount got=%0h exp=0", bus.stallCount); else pass_cnt++;
    total_cnt++; if (bus.stallF !== 1'b0) $display("FAIL rst_stallF got=%0h exp=0", bus.stallF); else pass_cnt++;
    total_cnt++; if (bus.branchTaken !== 1'b0) $display("FAIL rst_branchTaken got=%0h exp=0", bus.branchTaken); else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    load_if(ADD_R9_R8_R1, 32'h40);
    bus.regWeE = 1'b1; bus.memToRegE = 1'b1; bus.writeRegE = 5'd8;
    #1;
    total_cnt++; if (bus.stallF !== 1'b1) $display("FAIL lu_stallF got=%0h exp=1", bus.stallF); else pass_cnt++;
    tick();
    total_cnt++; if (bus.validE !== 1'b0) $display("FAIL lu_bubble_validE got=%0h exp=0", bus.validE); else pass_cnt++;
    total_cnt++; if (bus.stallCount !== 16'd1) $display("FAIL lu_stallCount got=%0h exp=1", bus.stallCount); else pass_cnt++;
    bus.regWeE = 1'b0; bus.memToRegE = 1'b0; bus.writeRegE = '0;
    #1;
    total_cnt++; if (bus.stallF !== 1'b0) $display("FAIL lu_release_stallF got=%0h exp=0", bus.stallF); else pass_cnt++;
    tick();
    total_cnt++; if (bus.validE !== 1'b1) $display("FAIL lu_issue_validE got=%0h exp=1", bus.validE); else pass_cnt++;
    total_cnt++; if (bus.instrE !== ADD_R9_R8_R1) $display("FAIL lu_issue_instrE got=%0h exp=%0h", bus.instrE, ADD_R9_R8_R1); else pass_cnt++;
    total_cnt++; if (bus.pcE !== 32'h40) $display("FAIL lu_issue_pcE got=%0h exp=40", bus.pcE); else pass_cnt++;
    total_cnt++; if (bus.destE !== 5'd9) $display("FAIL lu_destE got=%0h exp=9", bus.destE); else pass_cnt++;
    total_cnt++; if ({bus.rsE, bus.rtE, bus.rdE} !== {5'd8, 5'd1, 5'd9}) $display("FAIL lu_fields got=%0h/%0h/%0h exp=8/1/9", bus.rsE, bus.rtE, bus.rdE); else pass_cnt++;
    total_cnt++; if (bus.isLoadE !== 1'b0) $display("FAIL lu_isLoadE got=%0h exp=0", bus.isLoadE); else pass_cnt++;
    total_cnt++; if (bus.stallCount !== 16'd1) $display("FAIL lu_stallCount_hold got=%0h exp=1", bus.stallCount); else pass_cnt++;
  endtask

  task automatic test_writeback_bypass();
    load_if(ADD_R6_R5_R0, 32'h80);
    bus.regWeW = 1'b1; bus.writeRegW = 5'd5; bus.writeDataW = 32'hDEAD_BEEF;
    tick();
    bus.regWeW = 1'b0; bus.writeRegW = '0; bus.writeDataW = '0;
    total_cnt++; if (bus.readData1E !== 32'hDEAD_BEEF) $display("FAIL wb_bypass got=%0h exp=deadbeef", bus.readData1E); else pass_cnt++;
    total_cnt++; if (bus.readData2E !== 32'h0) $display("FAIL wb_rt_r0 got=%0h exp=0", bus.readData2E); else pass_cnt++;
    load_if(ADD_R6_R5_R0, 32'h84);
    tick();
    total_cnt++; if (bus.readData1E !== 32'hDEAD_BEEF) $display("FAIL wb_stored got=%0h exp=deadbeef", bus.readData1E); else pass_cnt++;
    load_if(ADD_R0_R0_R0, 32'h88);
    bus.regWeW = 1'b1; bus.writeRegW = 5'd0; bus.writeDataW = 32'h1234;
    tick();
    bus.regWeW = 1'b0; bus.writeRegW = '0; bus.writeDataW = '0;
    total_cnt++; if (bus.readData1E !== 32'h0) $display("FAIL wb_r0_bypass got=%0h exp=0", bus.readData1E); else pass_cnt++;
    load_if(ADD_R0_R0_R0, 32'h8C);
    tick();
    total_cnt++; if (bus.readData2E !== 32'h0) $display("FAIL wb_r0_stored got=%0h exp=0", bus.readData2E); else pass_cnt++;
  endtask

  task automatic test_branch_forward();
    wb_write(5'd4, 32'h55);
    // without forwarding r3=0 and r4=0x55 differ: not taken
    load_if(BEQ_R3_R4_4, 32'hF0);
    #1;
    total_cnt++; if (bus.branchTaken !== 1'b0) $display("FAIL bf_nottaken got=%0h exp=0", bus.branchTaken); else pass_cnt++;
    total_cnt++; if (bus.flushF !== 1'b0) $display("FAIL bf_noflush got=%0h exp=0", bus.flushF); else pass_cnt++;
    load_if(BEQ_R3_R4_4, 32'h100);
    bus.regWeM = 1'b1; bus.memToRegM = 1'b0; bus.writeRegM = 5'd3; bus.aluOutM = 32'h55;
    bus.validF = 1'b1; bus.instrF = 32'hFFFF_FFFF; bus.pcF = 32'h104;
    #1;
    total_cnt++; if (bus.branchTaken !== 1'b1) $display("FAIL bf_taken got=%0h exp=1", bus.branchTaken); else pass_cnt++;
    total_cnt++; if (bus.branchTarget !== 32'h114) $display("FAIL bf_target got=%0h exp=114", bus.branchTarget); else pass_cnt++;
    total_cnt++; if (bus.flushF !== 1'b1) $display("FAIL bf_flushF got=%0h exp=1", bus.flushF); else pass_cnt++;
    total_cnt++; if (bus.stallF !== 1'b0) $display("FAIL bf_stallF got=%0h exp=0", bus.stallF); else pass_cnt++;
    tick();
    idle_inputs();
    total_cnt++; if (bus.destE !== 5'd0) $display("FAIL bf_destE got=%0h exp=0", bus.destE); else pass_cnt++;
    tick();
    total_cnt++; if (bus.validE !== 1'b0) $display("FAIL bf_flushed_validE got=%0h exp=0", bus.validE); else pass_cnt++;
    total_cnt++; if (bus.instrE !== 32'h0) $display("FAIL bf_flushed_instrE got=%0h exp=0", bus.instrE); else pass_cnt++;
  endtask

  task automatic test_branch_after_alu();
    load_if(BNE_R3_R0_2, 32'h300);
    bus.regWeE = 1'b1; bus.memToRegE = 1'b0; bus.writeRegE = 5'd3;
    #1;
    total_cnt++; if (bus.stallF !== 1'b1) $display("FAIL ba_stallF got=%0h exp=1", bus.stallF); else pass_cnt++;
    total_cnt++; if (bus.branchTaken !== 1'b0) $display("FAIL ba_taken_in_stall got=%0h exp=0", bus.branchTaken); else pass_cnt++;
    tick();
    total_cnt++; if (bus.stallCount !== 16'd2) $display("FAIL ba_stallCount got=%0h exp=2", bus.stallCount); else pass_cnt++;
    bus.regWeE = 1'b0; bus.writeRegE = '0;
    bus.regWeM = 1'b1; bus.memToRegM = 1'b0; bus.writeRegM = 5'd3; bus.aluOutM = 32'h5;
    #1;
    total_cnt++; if (bus.branchTaken !== 1'b1) $display("FAIL ba_resolve got=%0h exp=1", bus.branchTaken); else pass_cnt++;
    total_cnt++; if (bus.branchTarget !== 32'h30C) $display("FAIL ba_target got=%0h exp=30c", bus.branchTarget); else pass_cnt++;
    tick();
    idle_inputs();
    total_cnt++; if (bus.instrE !== BNE_R3_R0_2) $display("FAIL ba_issue got=%0h exp=%0h", bus.instrE, BNE_R3_R0_2); else pass_cnt++;
  endtask

  task automatic test_branch_after_load();
    load_if(BEQ_R3_R4_4, 32'h400);
    bus.regWeM = 1'b1; bus.memToRegM = 1'b1; bus.writeRegM = 5'd4;
    #1;
    total_cnt++; if (bus.stallF !== 1'b1) $display("FAIL bl_stallF got=%0h exp=1", bus.stallF); else pass_cnt++;
    tick();
    idle_inputs();
    #1;
    total_cnt++; if (bus.stallF !== 1'b0) $display("FAIL bl_release got=%0h exp=0", bus.stallF); else pass_cnt++;
    total_cnt++; if (bus.branchTaken !== 1'b0) $display("FAIL bl_nottaken got=%0h exp=0", bus.branchTaken); else pass_cnt++;
    tick();
  endtask

  task automatic test_negative_offset();
    load_if(BEQ_R0_R0_M1, 32'h200);
    #1;
    total_cnt++; if (bus.branchTaken !== 1'b1) $display("FAIL neg_taken got=%0h exp=1", bus.branchTaken); else pass_cnt++;
    total_cnt++; if (bus.branchTarget !== 32'h200) $display("FAIL neg_target got=%0h exp=200", bus.branchTarget); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    total_cnt++; if (bus.stallCount !== 16'd3) $display("FAIL rm_pre_count got=%0h exp=3", bus.stallCount); else pass_cnt++;
    load_if(ADD_R9_R8_R1, 32'h500);
    bus.regWeE = 1'b1; bus.memToRegE = 1'b1; bus.writeRegE = 5'd8;
    #1;
    total_cnt++; if (bus.stallF !== 1'b1) $display("FAIL rm_stalling got=%0h exp=1", bus.stallF); else pass_cnt++;
    #1 rst = 1'b0;
    #1;
    total_cnt++; if (bus.stallF !== 1'b0) $display("FAIL rm_stallF got=%0h exp=0", bus.stallF); else pass_cnt++;
    total_cnt++; if (bus.stallCount !== 16'd0) $display("FAIL rm_stallCount got=%0h exp=0", bus.stallCount); else pass_cnt++;
    total_cnt++; if (bus.pcE !== 32'h0) $display("FAIL rm_pcE got=%0h exp=0", bus.pcE); else pass_cnt++;
    idle_inputs();
    tick();
    rst = 1'b1;
    load_if(ADD_R6_R5_R0, 32'h600);
    tick();
    total_cnt++; if (bus.validE !== 1'b1) $display("FAIL rm_first_validE got=%0h exp=1", bus.validE); else pass_cnt++;
    total_cnt++; if (bus.pcE !== 32'h600) $display("FAIL rm_first_pcE got=%0h exp=600", bus.pcE); else pass_cnt++;
    total_cnt++; if (bus.readData1E !== 32'h0) $display("FAIL rm_rf_cleared got=%0h exp=0", bus.readData1E); else pass_cnt++;
    total_cnt++; if (bus.stallCount !== 16'd0) $display("FAIL rm_count_after got=%0h exp=0", bus.stallCount); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_load_use();
    test_writeback_bypass();
    test_branch_forward();
    test_branch_after_alu();
    test_branch_after_load();
    test_negative_offset();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
